addsub_arbiter: RTL and testbench

// Round-robin arbiter and sequencer that shares one 16-bit add/subtract datapath among NREQ requesters.
// It accepts one operation per grant over a valid/ready handshake and drives the operand/mode registers into the shared unit.
// It captures sum and overflow one cycle later and returns them with the requester ID over a valid/ready response channel.
// It sits between the calculator front-end ports and the single add/sub instance.

---
 rtl/addsub_arbiter.sv | 139 +++++++++++++
 tb/tb_addsub_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter and sequencer sharing one add/subtract datapath among NREQ requesters.
// One operation in flight at a time: IDLE (grant) -> EXEC (datapath settles) -> RESP (hold result).
module addsub_arbiter #(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 16,
  parameter int OWIDTH = 32,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_p,
  input  logic [NREQ*WIDTH-1:0] req_q,
  input  logic [NREQ-1:0]       req_mode,
  output logic [WIDTH-1:0]      dp_p,
  output logic [WIDTH-1:0]      dp_q,
  output logic                  dp_mode,
  input  logic [OWIDTH-1:0]     dp_sum,
  input  logic                  dp_overflow,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [OWIDTH-1:0]     rsp_sum,
  output logic                  rsp_overflow,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]   dp_p_q, dp_p_d;
  logic [WIDTH-1:0]   dp_q_q, dp_q_d;
  logic               dp_mode_q, dp_mode_d;
  logic [IDW-1:0]     rsp_id_q, rsp_id_d;
  logic [OWIDTH-1:0]  rsp_sum_q, rsp_sum_d;
  logic               rsp_ovf_q, rsp_ovf_d;

  logic [WIDTH-1:0]   p_arr [NREQ];
  logic [WIDTH-1:0]   q_arr [NREQ];
  logic               grant_found;
  logic [IDW-1:0]     grant_idx;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign p_arr[g] = req_p[g*WIDTH +: WIDTH];
    assign q_arr[g] = req_q[g*WIDTH +: WIDTH];
  end

  // Two passes replace a modulo search: indices above the pointer win, then wrap to 0..ptr.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && req_valid[i] && (i > int'(rr_ptr_q))) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && req_valid[i] && (i <= int'(rr_ptr_q))) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values, independent of statement order.
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= IDW'(NREQ - 1);
      dp_p_q    <= '0;
      dp_q_q    <= '0;
      dp_mode_q <= 1'b0;
      rsp_id_q  <= '0;
      rsp_sum_q <= '0;
      rsp_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      dp_p_q    <= dp_p_d;
      dp_q_q    <= dp_q_d;
      dp_mode_q <= dp_mode_d;
      rsp_id_q  <= rsp_id_d;
      rsp_sum_q <= rsp_sum_d;
      rsp_ovf_q <= rsp_ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    dp_p_d    = dp_p_q;
    dp_q_d    = dp_q_q;
    dp_mode_d = dp_mode_q;
    rsp_id_d  = rsp_id_q;
    rsp_sum_d = rsp_sum_q;
    rsp_ovf_d = rsp_ovf_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          state_d   = EXEC;
          rr_ptr_d  = grant_idx;
          rsp_id_d  = grant_idx;
          dp_p_d    = p_arr[grant_idx];
          dp_q_d    = q_arr[grant_idx];
          dp_mode_d = req_mode[grant_idx];
        end
      end
      EXEC: begin
        state_d   = RESP;
        rsp_sum_d = dp_sum;
        rsp_ovf_d = dp_overflow;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The reset term keeps req_ready low for the whole reset pulse, not just after the next edge.
  always_comb begin
    req_ready = '0;
    busy      = (state_q != IDLE);
    rsp_valid = (state_q == RESP);
    if ((state_q == IDLE) && !rst && grant_found) req_ready[grant_idx] = 1'b1;
  end

  assign dp_p         = dp_p_q;
  assign dp_q         = dp_q_q;
  assign dp_mode      = dp_mode_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_sum      = rsp_sum_q;
  assign rsp_overflow = rsp_ovf_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: directed cases with literal expectations plus randomized traffic
// checked every cycle against a transaction-level model (grant order, pending op, arithmetic result).
module tb_addsub_arbiter;
  localparam int NREQ = 4, WIDTH = 16, OWIDTH = 32, IDW = 2;

  logic                  clk, rst;
  logic [NREQ-1:0]       req_valid, req_ready, req_mode;
  logic [NREQ*WIDTH-1:0] req_p, req_q;
  logic [WIDTH-1:0]      dp_p, dp_q;
  logic                  dp_mode, dp_overflow, rsp_valid, rsp_ready, rsp_overflow, busy;
  logic [OWIDTH-1:0]     dp_sum, rsp_sum;
  logic [IDW-1:0]        rsp_id;

  addsub_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .OWIDTH(OWIDTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_p(req_p), .req_q(req_q), .req_mode(req_mode),
    .dp_p(dp_p), .dp_q(dp_q), .dp_mode(dp_mode),
    .dp_sum(dp_sum), .dp_overflow(dp_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_overflow(rsp_overflow), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared add/sub unit: ripple form with carry-in = mode, overflow = carry[15] ^ carry[16].
  logic [16:0] dp_s;
  logic [15:0] dp_qx;
  always_comb begin
    dp_qx       = dp_mode ? ~dp_q : dp_q;
    dp_s        = {1'b0, dp_p} + {1'b0, dp_qx} + 17'(dp_mode);
    dp_sum      = {16'h0, dp_s[15:0]};
    dp_overflow = dp_s[16] ^ (dp_s[15] ^ dp_p[15] ^ dp_qx[15]);
  end

  int n_vec = 0, n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int model_grant(input int ptr, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (ptr + k) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic void ref_op(input logic [15:0] p, input logic [15:0] q, input logic m,
                                 output logic [31:0] sum, output logic ovf);
    int r;
    r   = m ? (int'($signed(p)) - int'($signed(q))) : (int'($signed(p)) + int'($signed(q)));
    sum = {16'h0, r[15:0]};
    ovf = (r > 32767) || (r < -32768);
  endfunction

  int          m_ptr, m_age, m_acc_id, mg;
  bit          m_pend, m_acc;
  logic [31:0] e_sum, ms;
  logic        e_ovf, mo, e_mode;
  logic [15:0] e_p, e_q;
  logic [IDW-1:0] e_id;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ptr  <= NREQ - 1;
      m_pend <= 1'b0;
      m_acc  <= 1'b0;
      m_age  <= 0;
    end else begin
      m_acc <= 1'b0;
      if (m_pend) begin
        if (m_age >= 1 && rsp_ready) m_pend <= 1'b0;
        else m_age <= m_age + 1;
      end else begin
        mg = model_grant(m_ptr, req_valid);
        if (mg >= 0) begin
          ref_op(req_p[mg*WIDTH +: WIDTH], req_q[mg*WIDTH +: WIDTH], req_mode[mg], ms, mo);
          m_pend   <= 1'b1;
          m_age    <= 0;
          m_ptr    <= mg;
          m_acc    <= 1'b1;
          m_acc_id <= mg;
          e_id     <= IDW'(mg);
          e_sum    <= ms;
          e_ovf    <= mo;
          e_p      <= req_p[mg*WIDTH +: WIDTH];
          e_q      <= req_q[mg*WIDTH +: WIDTH];
          e_mode   <= req_mode[mg];
        end
      end
    end
  end

  // Every-cycle compare, sampled on the falling edge.
  always @(negedge clk) begin
    logic [NREQ-1:0] er;
    int cg;
    er = '0;
    if (!rst && !m_pend) begin
      cg = model_grant(m_ptr, req_valid);
      if (cg >= 0) er = NREQ'(1) << cg;
    end
    check("req_ready", req_ready, er);
    check("busy", busy, m_pend);
    check("rsp_valid", rsp_valid, m_pend && m_age >= 1);
    if (m_pend && m_age >= 1) begin
      check("rsp_id", rsp_id, e_id);
      check("rsp_sum", rsp_sum, e_sum);
      check("rsp_overflow", rsp_overflow, e_ovf);
    end
    if (m_pend) begin
      check("dp_p", dp_p, e_p);
      check("dp_q", dp_q, e_q);
      check("dp_mode", dp_mode, e_mode);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int i, input logic [15:0] p, input logic [15:0] q, input logic m);
    req_valid[i]           = 1'b1;
    req_p[i*WIDTH +: WIDTH] = p;
    req_q[i*WIDTH +: WIDTH] = q;
    req_mode[i]            = m;
  endtask

  function automatic logic [15:0] rand_opnd();
    case ($urandom_range(0, 4))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'hFFFF;
      3: return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic wait_idle();
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (!m_pend) return;
    end
    check("wait_idle timeout", 1, 0);
  endtask

  task automatic wait_rsp(input string name, output int lat);
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) return;
    end
    check({name, " rsp timeout"}, 0, 1);
  endtask

  task automatic directed_op(input string name, input int id, input logic [15:0] p,
                             input logic [15:0] q, input logic m,
                             input logic [31:0] x_sum, input logic x_ovf);
    int lat;
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle();
    @(posedge clk); #2;
    set_req(id, p, q, m);
    @(negedge clk);
    check({name, " req_ready"}, req_ready, NREQ'(1) << id);
    @(posedge clk); #2;
    req_valid[id] = 1'b0;
    wait_rsp(name, lat);
    check({name, " latency"}, lat, 2);
    check({name, " sum"}, rsp_sum, x_sum);
    check({name, " ovf"}, rsp_overflow, x_ovf);
    check({name, " id"}, rsp_id, id);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, cyc, nrsp, last_cyc;
    rst = 1'b1; req_valid = '0; req_p = '0; req_q = '0; req_mode = '0; rsp_ready = 1'b0;
    req_valid = 4'b1111;
    #1;
    check("reset req_ready", req_ready, 0);
    check("reset busy", busy, 0);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset dp_p", dp_p, 0);
    check("reset rsp_sum", rsp_sum, 0);
    req_valid = '0;
    @(posedge clk); #2 rst = 1'b0;

    directed_op("add", 0, 16'd31, 16'd3, 1'b0, 32'd34, 1'b0);
    directed_op("sub", 2, 16'd3, 16'd31, 1'b1, 32'h0000FFE4, 1'b0);
    directed_op("ovf_add", 1, 16'h7FFF, 16'd1, 1'b0, 32'h00008000, 1'b1);
    directed_op("ovf_sub", 3, 16'h8000, 16'd1, 1'b1, 32'h00007FFF, 1'b1);

    // Round-robin from a fresh reset: ids 0,1,2,3,... one response every 3 cycles.
    wait_idle();
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 16'(i * 100 + 1), 16'(i), i[0]);
    nrsp = 0; last_cyc = 0;
    for (cyc = 0; cyc < 80 && nrsp < 12; cyc++) begin
      @(negedge clk);
      if (rsp_valid) begin
        check("rr id", rsp_id, nrsp % NREQ);
        if (nrsp > 0) check("rr spacing", cyc - last_cyc, 3);
        last_cyc = cyc;
        nrsp++;
      end
    end
    check("rr count", nrsp, 12);
    req_valid = '0;

    // Backpressure while requester 1 waits.
    wait_idle();
    rsp_ready = 1'b0;
    @(posedge clk); #2 set_req(0, 16'd1000, 16'd24, 1'b0);
    @(posedge clk); #2 req_valid[0] = 1'b0;
    set_req(1, 16'd5, 16'd7, 1'b1);
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("bp rsp_valid", rsp_valid, 1);
      check("bp rsp_sum", rsp_sum, 32'h400);
      check("bp req_ready", req_ready, 0);
      check("bp busy", busy, 1);
      if (k < 4) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp regrant", req_ready, 4'b0010);
    @(posedge clk); #2 req_valid[1] = 1'b0;
    wait_rsp("bp", lat);
    check("bp id1", rsp_id, 1);
    check("bp sum1", rsp_sum, 32'h0000FFFE);

    // Reset during EXEC discards the operation and restores the pointer.
    wait_idle();
    @(posedge clk); #2 set_req(3, 16'h1234, 16'h1111, 1'b0);
    @(posedge clk); #2;
    #1 rst = 1'b1;
    #1;
    check("rx rsp_valid", rsp_valid, 0);
    check("rx busy", busy, 0);
    check("rx req_ready", req_ready, 0);
    check("rx dp_p", dp_p, 0);
    check("rx dp_q", dp_q, 0);
    check("rx dp_mode", dp_mode, 0);
    @(posedge clk); #2 rst = 1'b0;
    set_req(0, 16'd9, 16'd9, 1'b0);
    @(negedge clk);
    check("rx next grant", req_ready, 4'b0001);
    @(posedge clk); #2 req_valid = '0;
    wait_rsp("rx", lat);
    check("rx id", rsp_id, 0);
    check("rx sum", rsp_sum, 32'd18);

    // Randomized traffic, including withdrawals and response backpressure.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      for (int i = 0; i < NREQ; i++) begin
        if (m_acc && m_acc_id == i) begin
          if ($urandom_range(0, 9) < 6) set_req(i, rand_opnd(), rand_opnd(), 1'($urandom));
          else req_valid[i] = 1'b0;
        end else if (!req_valid[i]) begin
          if ($urandom_range(0, 9) < 3) set_req(i, rand_opnd(), rand_opnd(), 1'($urandom));
        end else if ($urandom_range(0, 49) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (8) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
